// File: rtl/seg7_scan_reader.sv
// ---------------------------------------------------------------------------
// seg7_scan_reader
//
// Reads back a multiplexed, active-low 7-segment display bus (segment lines
// plus per-digit anode strobes) and recovers the hex value shown on each
// digit. It is meant for loop-back self-checking of a display-driving path.
//
// Optional feature macro: SEG7_READER_DP_EN (decimal point read-back).
//
// Parameters:
//   NDIG    number of multiplexed digits (1..8)
//   STABLE  consecutive identical synchronised samples needed for a capture
//   TIMEOUT cycles without a capture before a digit's valid is dropped
//
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   seg      segment lines, active-low, bit0=a .. bit6=g
//   an_n     digit strobes, active-low, bit i = digit i
//   dp_n     (SEG7_READER_DP_EN only) decimal point, active-low
//   dp       (SEG7_READER_DP_EN only) per-digit decimal point state
//   hex      decoded values, digit i in bits [4i+3:4i]
//   valid    digit holds a fresh legal value
//   blank    digit last seen blank
//   upd      one-cycle pulse on a legal or blank capture
//   err      one-cycle pulse on a capture of an illegal pattern
// ---------------------------------------------------------------------------
module seg7_scan_reader #(
  parameter int NDIG    = 4,
  parameter int STABLE  = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [6:0]        seg,
  input  logic [NDIG-1:0]   an_n,
`ifdef SEG7_READER_DP_EN
  input  logic              dp_n,
  output logic [NDIG-1:0]   dp,
`endif
  output logic [4*NDIG-1:0] hex,
  output logic [NDIG-1:0]   valid,
  output logic [NDIG-1:0]   blank,
  output logic              upd,
  output logic              err
);

  // Sample word layout: {[dp_n], an_n, seg}
`ifdef SEG7_READER_DP_EN
  localparam int SW = 8 + NDIG;
`else
  localparam int SW = 7 + NDIG;
`endif

  localparam logic [7:0]  STABLE_C  = 8'(STABLE);
  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);
  localparam logic [15:0] TO_LAST_C = 16'(TIMEOUT - 1);

  logic [SW-1:0]   raw_in;
  logic [SW-1:0]   sync1_q;
  logic [SW-1:0]   sync2_q;
  logic [SW-1:0]   samp_q;     // previous synchronised sample
  logic [7:0]      cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            capture;
  logic [NDIG-1:0] cap_an_n;
  logic [6:0]      cap_seg;
  logic            cap_legal;
  logic            cap_blank;
  logic [3:0]      cap_val;
  logic            upd_q;
  logic            err_q;

`ifdef SEG7_READER_DP_EN
  assign raw_in = {dp_n, an_n, seg};
`else
  assign raw_in = {an_n, seg};
`endif

  // True when exactly one strobe line is low.
  function automatic logic one_low(input logic [NDIG-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < NDIG; i++) begin
      if (!v[i]) n = n + 1;
    end
    return (n == 1);
  endfunction

  // The counter describes how long samp_q has been held, so a capture
  // always decodes samp_q, even if the live sample moves on that cycle.
  always_comb begin
    capture = (cnt_q == STABLE_C) && !done_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    if (!one_low(sync2_q[7 +: NDIG])) begin
      cnt_d  = 8'd0;
      done_d = 1'b0;
    end else if (sync2_q == samp_q) begin
      if (cnt_q != STABLE_C) cnt_d = cnt_q + 8'd1;
      if (capture)           done_d = 1'b1;
    end else begin
      cnt_d  = 8'd1;
      done_d = 1'b0;
    end
  end

  assign cap_an_n = samp_q[7 +: NDIG];
  assign cap_seg  = samp_q[6:0];
  assign cap_blank = (cap_seg == 7'h7F);

  // Inverse of the hex-to-segment decode (active-low gfedcba).
  always_comb begin
    cap_legal = 1'b1;
    cap_val   = 4'h0;
    case (cap_seg)
      7'h40: cap_val = 4'h0;
      7'h79: cap_val = 4'h1;
      7'h24: cap_val = 4'h2;
      7'h30: cap_val = 4'h3;
      7'h19: cap_val = 4'h4;
      7'h12: cap_val = 4'h5;
      7'h02: cap_val = 4'h6;
      7'h78: cap_val = 4'h7;
      7'h00: cap_val = 4'h8;
      7'h10: cap_val = 4'h9;
      7'h08: cap_val = 4'hA;
      7'h03: cap_val = 4'hB;
      7'h46: cap_val = 4'hC;
      7'h21: cap_val = 4'hD;
      7'h06: cap_val = 4'hE;
      7'h0E: cap_val = 4'hF;
      default: cap_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      samp_q  <= '0;
      cnt_q   <= 8'd0;
      done_q  <= 1'b0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
      samp_q  <= sync2_q;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      upd_q   <= capture && (cap_legal || cap_blank);
      err_q   <= capture && !cap_legal && !cap_blank;
    end
  end

  assign upd = upd_q;
  assign err = err_q;

  for (genvar gi = 0; gi < NDIG; gi++) begin : g_dig
    logic        sel;
    logic [3:0]  hex_q;
    logic        valid_q;
    logic        blank_q;
    logic [15:0] to_q;

    // A capture is always a one-hot strobe, so at most one digit selects.
    assign sel = capture && !cap_an_n[gi];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        hex_q   <= 4'h0;
        valid_q <= 1'b0;
        blank_q <= 1'b0;
        to_q    <= 16'd0;
      end else if (sel) begin
        // Capture beats a simultaneous timeout; every capture kind
        // restarts the staleness counter.
        to_q <= 16'd0;
        if (cap_legal) begin
          hex_q   <= cap_val;
          valid_q <= 1'b1;
          blank_q <= 1'b0;
        end else if (cap_blank) begin
          valid_q <= 1'b0;
          blank_q <= 1'b1;
        end
      end else begin
        if (to_q != TIMEOUT_C) to_q <= to_q + 16'd1;
        if (to_q == TO_LAST_C) valid_q <= 1'b0;
      end
    end

    assign hex[4*gi +: 4] = hex_q;
    assign valid[gi]      = valid_q;
    assign blank[gi]      = blank_q;

`ifdef SEG7_READER_DP_EN
    logic dp_q;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        dp_q <= 1'b0;
      end else if (sel && (cap_legal || cap_blank)) begin
        dp_q <= ~samp_q[SW-1];
      end
    end
    assign dp[gi] = dp_q;
`endif
  end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_reader
//
// Self-checking bench for seg7_scan_reader (NDIG=4, STABLE=4, TIMEOUT=40).
// A pin-level reference model tracks how long each driven value has been
// held; a value held STABLE cycles yields a capture whose effect appears
// three bench steps later. Directed tables and sequences cover scan, filter,
// blank, timeout and asynchronous reset; a random phase follows.
// Honours SEG7_READER_DP_EN for the decimal-point read-back.
// ---------------------------------------------------------------------------
module tb_seg7_scan_reader;
  localparam int NDIG    = 4;
  localparam int STABLE  = 4;
  localparam int TIMEOUT = 40;

  localparam logic [6:0] PAT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic              clk;
  logic              reset_n;
  logic [6:0]        seg;
  logic [NDIG-1:0]   an_n;
  logic [4*NDIG-1:0] hex;
  logic [NDIG-1:0]   valid;
  logic [NDIG-1:0]   blank;
  logic              upd;
  logic              err;
  logic              drv_dpn;
`ifdef SEG7_READER_DP_EN
  logic              dp_n;
  logic [NDIG-1:0]   dp;
`endif

  seg7_scan_reader #(.NDIG(NDIG), .STABLE(STABLE), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .seg     (seg),
    .an_n    (an_n),
`ifdef SEG7_READER_DP_EN
    .dp_n    (dp_n),
    .dp      (dp),
`endif
    .hex     (hex),
    .valid   (valid),
    .blank   (blank),
    .upd     (upd),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int              due;
    logic [NDIG-1:0] an;
    logic [6:0]      sg;
    logic            dpn;
  } cap_t;

  typedef struct {
    logic [NDIG-1:0]   an;
    logic [6:0]        sg;
    int                hold;
    logic [4*NDIG-1:0] ehex;
    logic [NDIG-1:0]   evalid;
    int                eupd;
    int                eerr;
  } vec_t;

  cap_t              pend[$];
  logic [4*NDIG-1:0] m_hex;
  logic [NDIG-1:0]   m_valid;
  logic [NDIG-1:0]   m_blank;
`ifdef SEG7_READER_DP_EN
  logic [NDIG-1:0]   m_dp;
`endif
  logic              m_upd;
  logic              m_err;
  int                last_cap [NDIG];
  int                it;
  int                run;
  logic              have_prev;
  logic [NDIG+7:0]   prev_key;
  int                upd_cnt;
  int                err_cnt;
  int                last_it;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int zero_idx(input logic [NDIG-1:0] a);
    for (int i = 0; i < NDIG; i++) if (!a[i]) return i;
    return 0;
  endfunction

  function automatic bit one_low(input logic [NDIG-1:0] a);
    int n;
    n = 0;
    for (int i = 0; i < NDIG; i++) if (!a[i]) n++;
    return (n == 1);
  endfunction

  task automatic model_reset();
    m_hex   = '0;
    m_valid = '0;
    m_blank = '0;
`ifdef SEG7_READER_DP_EN
    m_dp    = '0;
`endif
    m_upd   = 1'b0;
    m_err   = 1'b0;
    pend.delete();
    run       = 0;
    have_prev = 1'b0;
    for (int d = 0; d < NDIG; d++) last_cap[d] = -1000000;
  endtask

  task automatic apply_cap(input cap_t e);
    int d;
    int f;
    d = zero_idx(e.an);
    f = -1;
    for (int k = 0; k < 16; k++) if (PAT[k] == e.sg) f = k;
    if (f >= 0) begin
      m_hex[4*d +: 4] = 4'(f);
      m_valid[d] = 1'b1;
      m_blank[d] = 1'b0;
      m_upd      = 1'b1;
`ifdef SEG7_READER_DP_EN
      m_dp[d]    = ~e.dpn;
`endif
    end else if (e.sg == 7'h7F) begin
      m_valid[d] = 1'b0;
      m_blank[d] = 1'b1;
      m_upd      = 1'b1;
`ifdef SEG7_READER_DP_EN
      m_dp[d]    = ~e.dpn;
`endif
    end else begin
      m_err = 1'b1;
    end
    last_cap[d] = it;
  endtask

  // Drive one cycle of pins, advance the model, compare every output.
  task automatic step(input logic [NDIG-1:0] a, input logic [6:0] s);
    logic [NDIG+7:0] key;
    cap_t e;
    an_n = a;
    seg  = s;
`ifdef SEG7_READER_DP_EN
    dp_n = drv_dpn;
`endif
    key = {drv_dpn, a, s};
    if (!one_low(a)) run = 0;
    else if (have_prev && key == prev_key) begin
      if (run < 1000) run++;
    end else run = 1;
    prev_key  = key;
    have_prev = 1'b1;
    if (run == STABLE) begin
      e.due = it + 3;
      e.an  = a;
      e.sg  = s;
      e.dpn = drv_dpn;
      pend.push_back(e);
    end
    @(posedge clk);
    #1;
    m_upd = 1'b0;
    m_err = 1'b0;
    for (int d = 0; d < NDIG; d++)
      if (m_valid[d] && it == last_cap[d] + TIMEOUT) m_valid[d] = 1'b0;
    if (pend.size() > 0 && pend[0].due == it) begin
      apply_cap(pend[0]);
      void'(pend.pop_front());
    end
    chk($sformatf("step%0d hex/valid/blank/upd/err", it),
        64'({hex, valid, blank, upd, err}),
        64'({m_hex, m_valid, m_blank, m_upd, m_err}));
`ifdef SEG7_READER_DP_EN
    chk($sformatf("step%0d dp", it), 64'(dp), 64'(m_dp));
`endif
    upd_cnt += int'(upd);
    err_cnt += int'(err);
    last_it = it;
    it++;
  endtask

  task automatic hard_reset();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  vec_t tbl [8];

  initial begin
    int first, upd_it, fall_it, typ, hold, d;
    logic [NDIG-1:0] a;
    logic [6:0] s;

    reset_n = 1'b0;
    seg     = 7'h7F;
    an_n    = '1;
    drv_dpn = 1'b1;
`ifdef SEG7_READER_DP_EN
    dp_n    = 1'b1;
`endif
    it      = 0;
    last_it = 0;
    upd_cnt = 0;
    err_cnt = 0;
    model_reset();

    tbl[0] = '{4'b1110, 7'h79, 8, 16'h0001, 4'b0001, 1, 0};
    tbl[1] = '{4'b1101, 7'h08, 8, 16'h00A1, 4'b0011, 1, 0};
    tbl[2] = '{4'b1011, 7'h0E, 8, 16'h0FA1, 4'b0111, 1, 0};
    tbl[3] = '{4'b0111, 7'h78, 8, 16'h7FA1, 4'b1111, 1, 0};
    tbl[4] = '{4'b1110, 7'h79, 8, 16'h7FA1, 4'b1111, 1, 0};
    tbl[5] = '{4'b1101, 7'h08, 8, 16'h7FA1, 4'b1111, 1, 0};
    tbl[6] = '{4'b1011, 7'h01, 8, 16'h7FA1, 4'b1111, 0, 1};
    tbl[7] = '{4'b0111, 7'h78, 8, 16'h7FA1, 4'b1111, 1, 0};

    // Reset held while pins toggle
    for (int i = 0; i < 6; i++) begin
      an_n = 4'($urandom);
      seg  = 7'($urandom);
      @(posedge clk);
      #1;
      chk("reset_hold outputs", 64'({hex, valid, blank, upd, err}), 64'd0);
    end
    reset_n = 1'b1;
    model_reset();

    // First capture latency
    first = -1;
    upd_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(4'b1110, 7'h24);
      if (upd && first < 0) first = i;
    end
    chk("first_capture step", 64'(first), 64'(STABLE + 2));
    chk("first_capture upd pulses", 64'(upd_cnt), 64'd1);
    chk("first_capture hex0", 64'(hex[3:0]), 64'h2);
    chk("first_capture valid", 64'(valid), 64'b0001);

    // Full scan table
    hard_reset();
    for (int r = 0; r < 8; r++) begin
      upd_cnt = 0;
      err_cnt = 0;
      for (int k = 0; k < tbl[r].hold; k++) step(tbl[r].an, tbl[r].sg);
      chk($sformatf("scan%0d hex", r), 64'(hex), 64'(tbl[r].ehex));
      chk($sformatf("scan%0d valid", r), 64'(valid), 64'(tbl[r].evalid));
      chk($sformatf("scan%0d upd pulses", r), 64'(upd_cnt), 64'(tbl[r].eupd));
      chk($sformatf("scan%0d err pulses", r), 64'(err_cnt), 64'(tbl[r].eerr));
    end

    // Stability filter: changes every 3 cycles never capture
    upd_cnt = 0;
    err_cnt = 0;
    for (int g = 0; g < 8; g++) repeat (3) step(4'b1110, PAT[g]);
    chk("filter upd+err", 64'(upd_cnt + err_cnt), 64'd0);
    repeat (3) step(4'b1101, 7'h19);
    repeat (2) step(4'b1100, 7'h19);
    repeat (3) step(4'b1101, 7'h19);
    chk("glitch upd+err", 64'(upd_cnt + err_cnt), 64'd0);
    repeat (5) step(4'b1101, 7'h19);
    chk("glitch recapture upd", 64'(upd_cnt), 64'd1);
    chk("glitch recapture hex1", 64'(hex[7:4]), 64'h4);

    // Blank digit 1
    repeat (8) step(4'b1101, 7'h7F);
    chk("blank valid1", 64'(valid[1]), 64'd0);
    chk("blank blank1", 64'(blank[1]), 64'd1);
    chk("blank hex1 kept", 64'(hex[7:4]), 64'h4);

    // Timeout on digit 0
    upd_it = -1;
    for (int i = 0; i < 8; i++) begin
      step(4'b1110, 7'h12);
      if (upd) upd_it = last_it;
    end
    chk("timeout valid0 set", 64'(valid[0]), 64'd1);
    fall_it = -1;
    for (int i = 0; i < 100 && fall_it < 0; i++) begin
      step(4'b1111, 7'h7F);
      if (!valid[0]) fall_it = last_it;
    end
    chk("timeout delay", 64'(fall_it - upd_it), 64'(TIMEOUT));
    chk("timeout hex0 kept", 64'(hex[3:0]), 64'h5);

    // Asynchronous reset in the middle of a window
    repeat (8) step(4'b0111, 7'h78);
    repeat (4) step(4'b1011, 7'h30);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async reset outputs", 64'({hex, valid, blank, upd, err}), 64'd0);
    #1;
    reset_n = 1'b1;
    model_reset();
    first = -1;
    for (int i = 0; i < 20; i++) begin
      step(4'b1011, 7'h30);
      if (upd && first < 0) first = i;
    end
    chk("post-reset full window", 64'(first), 64'(STABLE + 2));

`ifdef SEG7_READER_DP_EN
    drv_dpn = 1'b0;
    repeat (8) step(4'b1110, 7'h12);
    chk("dp0 on", 64'(dp[0]), 64'd1);
    drv_dpn = 1'b1;
    upd_cnt = 0;
    repeat (8) step(4'b1110, 7'h12);
    chk("dp0 off", 64'(dp[0]), 64'd0);
    chk("dp-only change upd", 64'(upd_cnt), 64'd1);
`endif

    // Random traffic against the model
    for (int n = 0; n < 250; n++) begin
      typ  = $urandom_range(0, 9);
      hold = $urandom_range(1, 8);
      d    = $urandom_range(0, NDIG - 1);
      a    = '1;
      a[d] = 1'b0;
      if (typ < 7)       s = PAT[$urandom_range(0, 15)];
      else if (typ == 7) s = 7'h7F;
      else if (typ == 8) s = 7'($urandom);
      else begin
        s = PAT[$urandom_range(0, 15)];
        a = 4'($urandom);
        if (one_low(a)) a = 4'b0110;
      end
`ifdef SEG7_READER_DP_EN
      drv_dpn = 1'($urandom_range(0, 1));
`endif
      repeat (hold) step(a, s);
    end
    repeat (8) step(4'b1111, 7'h7F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
